onehot_strobe_decoder: RTL and testbench



---
 rtl/onehot_strobe_decoder.sv | 122 ++++++++++++
 tb/tb_onehot_strobe_decoder.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_strobe_decoder.sv
// Sequential 3-to-8 decoder: accepts a binary code over valid/ready and drives the
// matching one-hot line for HOLD cycles, then enforces a GAP idle period.
module onehot_strobe_decoder #(
    parameter int SEL_W = 3,
    parameter int OUT_W = 8,
    parameter int HOLD  = 4,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [SEL_W-1:0] code_in,
    output logic             in_ready,
    input  logic             abort,
    output logic [OUT_W-1:0] out,
    output logic             busy,
    output logic             done
);

    localparam int HOLD_EFF  = (HOLD < 1) ? 1 : HOLD;
    localparam int GAP_MAX   = (GAP > 0) ? GAP - 1 : 0;
    localparam int CNT_MAX   = ((HOLD_EFF - 1) > GAP_MAX) ? (HOLD_EFF - 1) : GAP_MAX;
    localparam int CNT_W     = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_EFF - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_MAX);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [SEL_W-1:0] code_q, code_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic             inReady_q, inReady_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    function automatic logic [OUT_W-1:0] decodeIndex(input logic [SEL_W-1:0] idx);
        logic [OUT_W-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

    // Outputs are computed from the next state so every output is a plain flop.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        code_d    = code_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && inReady_q && !abort) begin
                    code_d  = code_in;
                    count_d = HOLD_LOAD;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (abort) begin
                    count_d = '0;
                    state_d = ST_IDLE;
                end else if (count_q == '0) begin
                    done_d = 1'b1;
                    if (GAP > 0) begin
                        count_d = GAP_LOAD;
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (abort || count_q == '0) begin
                    count_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            default: begin
                count_d = '0;
                state_d = ST_IDLE;
            end
        endcase

        out_d     = (state_d == ST_DRIVE) ? decodeIndex(code_d) : '0;
        busy_d    = (state_d != ST_IDLE);
        inReady_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            code_q    <= '0;
            out_q     <= '0;
            inReady_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            code_q    <= code_d;
            out_q     <= out_d;
            inReady_q <= inReady_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign out      = out_q;
    assign in_ready = inReady_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_onehot_strobe_decoder.sv
// Directed bench for onehot_strobe_decoder: default HOLD=4/GAP=1 instance plus a
// HOLD=0/GAP=0 instance sharing the clock and reset.
module tb_onehot_strobe_decoder;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [2:0] code_in;
    logic       abort;
    logic       in_ready;
    logic [7:0] out;
    logic       busy;
    logic       done;

    logic       inValid2;
    logic [2:0] codeIn2;
    logic       abort2;
    logic       inReady2;
    logic [7:0] out2;
    logic       busy2;
    logic       done2;

    int checks = 0;
    int errors = 0;

    onehot_strobe_decoder #(.SEL_W(3), .OUT_W(8), .HOLD(4), .GAP(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .code_in(code_in),
        .in_ready(in_ready), .abort(abort), .out(out), .busy(busy), .done(done)
    );

    onehot_strobe_decoder #(.SEL_W(3), .OUT_W(8), .HOLD(0), .GAP(0)) dutFast (
        .clk(clk), .rst(rst), .in_valid(inValid2), .code_in(codeIn2),
        .in_ready(inReady2), .abort(abort2), .out(out2), .busy(busy2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // status = {out, in_ready, busy, done}
    task automatic test_reset();
        logic [10:0] st;
        rst = 1'b1; in_valid = 1'b0; code_in = 3'd0; abort = 1'b0;
        inValid2 = 1'b0; codeIn2 = 3'd0; abort2 = 1'b0;
        #2;
        st = {out, in_ready, busy, done};
        checks++;
        if (st !== 11'h000) begin
            errors++; $display("[TB] FAIL reset_hold: got %h expected %h", st, 11'h000);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        st = {out, in_ready, busy, done};
        checks++;
        if (st !== {8'h00, 3'b100}) begin
            errors++; $display("[TB] FAIL reset_release: got %h expected %h", st, {8'h00, 3'b100});
        end
        st = {out2, inReady2, busy2, done2};
        checks++;
        if (st !== {8'h00, 3'b100}) begin
            errors++; $display("[TB] FAIL reset_release_fast: got %h expected %h", st, {8'h00, 3'b100});
        end
    endtask

    task automatic test_single();
        logic [10:0] st;
        in_valid = 1'b1; code_in = 3'b101;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            st = {out, in_ready, busy, done};
            checks++;
            if (st !== {8'b0010_0000, 3'b010}) begin
                errors++; $display("[TB] FAIL single_drive[%0d]: got %h expected %h", i, st, {8'b0010_0000, 3'b010});
            end
            tick();
        end
        st = {out, in_ready, busy, done};
        checks++;
        if (st !== {8'h00, 3'b011}) begin
            errors++; $display("[TB] FAIL single_done: got %h expected %h", st, {8'h00, 3'b011});
        end
        tick();
        st = {out, in_ready, busy, done};
        checks++;
        if (st !== {8'h00, 3'b100}) begin
            errors++; $display("[TB] FAIL single_idle: got %h expected %h", st, {8'h00, 3'b100});
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] st;
        logic [7:0]  expOut;
        code_in = 3'd0; in_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            expOut = 8'h01 << c;
            for (int i = 0; i < 4; i++) begin
                tick();
                st = {out, in_ready, busy, done};
                checks++;
                if (st !== {expOut, 3'b010}) begin
                    errors++; $display("[TB] FAIL sweep_drive[%0d.%0d]: got %h expected %h", c, i, st, {expOut, 3'b010});
                end
                checks++;
                if ($countones(out) > 1) begin
                    errors++; $display("[TB] FAIL sweep_onehot[%0d.%0d]: got %b expected at most one bit", c, i, out);
                end
            end
            tick();
            st = {out, in_ready, busy, done};
            checks++;
            if (st !== {8'h00, 3'b011}) begin
                errors++; $display("[TB] FAIL sweep_done[%0d]: got %h expected %h", c, st, {8'h00, 3'b011});
            end
            if (c < 7) code_in = 3'(c + 1);
            else in_valid = 1'b0;
            tick();
            st = {out, in_ready, busy, done};
            checks++;
            if (st !== {8'h00, 3'b100}) begin
                errors++; $display("[TB] FAIL sweep_idle[%0d]: got %h expected %h", c, st, {8'h00, 3'b100});
            end
        end
    endtask

    task automatic test_abort();
        logic [10:0] st;
        in_valid = 1'b1; code_in = 3'b010;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out !== 8'h04) begin
            errors++; $display("[TB] FAIL abort_drive1: got %h expected %h", out, 8'h04);
        end
        tick();
        checks++;
        if (out !== 8'h04) begin
            errors++; $display("[TB] FAIL abort_drive2: got %h expected %h", out, 8'h04);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        st = {out, in_ready, busy, done};
        checks++;
        if (st !== {8'h00, 3'b100}) begin
            errors++; $display("[TB] FAIL abort_cancel: got %h expected %h", st, {8'h00, 3'b100});
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if ({done, out} !== 9'h000) begin
                errors++; $display("[TB] FAIL abort_no_done[%0d]: got %h expected %h", i, {done, out}, 9'h000);
            end
        end
    endtask

    task automatic test_abort_idle();
        logic [10:0] st;
        in_valid = 1'b1; code_in = 3'd3; abort = 1'b1;
        tick();
        abort = 1'b0;
        st = {out, in_ready, busy, done};
        checks++;
        if (st !== {8'h00, 3'b100}) begin
            errors++; $display("[TB] FAIL abort_idle_block: got %h expected %h", st, {8'h00, 3'b100});
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out !== 8'h08) begin
            errors++; $display("[TB] FAIL abort_idle_accept: got %h expected %h", out, 8'h08);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        st = {out, in_ready, busy, done};
        checks++;
        if (st !== {8'h00, 3'b100}) begin
            errors++; $display("[TB] FAIL abort_first_cycle: got %h expected %h", st, {8'h00, 3'b100});
        end
    endtask

    task automatic test_reset_mid_drive();
        logic [10:0] st;
        in_valid = 1'b1; code_in = 3'd6;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out !== 8'h40) begin
            errors++; $display("[TB] FAIL rstmid_drive: got %h expected %h", out, 8'h40);
        end
        #3;
        rst = 1'b1;
        #1;
        st = {out, in_ready, busy, done};
        checks++;
        if (st !== 11'h000) begin
            errors++; $display("[TB] FAIL rstmid_async_clear: got %h expected %h", st, 11'h000);
        end
        #2;
        rst = 1'b0;
        tick();
        st = {out, in_ready, busy, done};
        checks++;
        if (st !== {8'h00, 3'b100}) begin
            errors++; $display("[TB] FAIL rstmid_release: got %h expected %h", st, {8'h00, 3'b100});
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({done, busy} !== 2'b00) begin
                errors++; $display("[TB] FAIL rstmid_no_done[%0d]: got %b expected %b", i, {done, busy}, 2'b00);
            end
        end
        in_valid = 1'b1; code_in = 3'd1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out !== 8'h02) begin
            errors++; $display("[TB] FAIL rstmid_reaccept: got %h expected %h", out, 8'h02);
        end
        repeat (6) tick();
    endtask

    task automatic test_hold_zero();
        logic [10:0] st;
        inValid2 = 1'b1; codeIn2 = 3'b111;
        tick();
        inValid2 = 1'b0;
        st = {out2, inReady2, busy2, done2};
        checks++;
        if (st !== {8'h80, 3'b010}) begin
            errors++; $display("[TB] FAIL hold0_drive: got %h expected %h", st, {8'h80, 3'b010});
        end
        tick();
        st = {out2, inReady2, busy2, done2};
        checks++;
        if (st !== {8'h00, 3'b101}) begin
            errors++; $display("[TB] FAIL hold0_done: got %h expected %h", st, {8'h00, 3'b101});
        end
        tick();
        st = {out2, inReady2, busy2, done2};
        checks++;
        if (st !== {8'h00, 3'b100}) begin
            errors++; $display("[TB] FAIL hold0_idle: got %h expected %h", st, {8'h00, 3'b100});
        end
        inValid2 = 1'b1; codeIn2 = 3'd3;
        tick();
        checks++;
        if (out2 !== 8'h08) begin
            errors++; $display("[TB] FAIL hold0_b2b_first: got %h expected %h", out2, 8'h08);
        end
        tick();
        st = {out2, inReady2, busy2, done2};
        checks++;
        if (st !== {8'h00, 3'b101}) begin
            errors++; $display("[TB] FAIL hold0_b2b_done: got %h expected %h", st, {8'h00, 3'b101});
        end
        codeIn2 = 3'd4;
        tick();
        inValid2 = 1'b0;
        checks++;
        if (out2 !== 8'h10) begin
            errors++; $display("[TB] FAIL hold0_b2b_second: got %h expected %h", out2, 8'h10);
        end
        tick();
        checks++;
        if ({out2, done2} !== 9'h001) begin
            errors++; $display("[TB] FAIL hold0_b2b_done2: got %h expected %h", {out2, done2}, 9'h001);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_abort();
        test_abort_idle();
        test_reset_mid_drive();
        test_hold_zero();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
